// File: rtl/trig_edge_qual.sv
// Purpose : qualify the polarity-selected trigger line into one-cycle trigger pulses (optional glitch filter, arm FSM, holdoff).
// Latency : Sin rise to Trig is 2 edges without the filter, FILT_LEN+2 edges with it.
// Backpr. : none; edges seen while IDLE or HOLDOFF are dropped and never queued.
//
// Optional feature macro: TRIG_GLITCH_FILTER_EN
//   defined   -> Sin passes through a FILT_LEN-deep majority-free glitch filter
//                (level changes only after FILT_LEN identical samples)
//   undefined -> Sin is simply registered once
//
// Ports
//   Clock      sole clock, rising edge
//   Reset      synchronous active-high, clears all state
//   Sin        polarity-corrected trigger level
//   Arm        single-cycle request to leave IDLE
//   Disarm     forces IDLE from any state, wins over Arm
//   Single     1 = single-shot, 0 = continuous re-arm
//   Holdoff    dead time after a trigger in cycles, captured when Trig fires
//   Trig       registered one-cycle trigger pulse
//   Armed      FSM is in ARMED
//   Busy       FSM is in HOLDOFF
//   TrigCount  issued-trigger count, wraps 0xFFFF -> 0x0000

module trig_edge_qual #(
    parameter int FILT_LEN = 4,
    parameter int HOLD_W   = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Sin,
    input  logic              Arm,
    input  logic              Disarm,
    input  logic              Single,
    input  logic [HOLD_W-1:0] Holdoff,
    output logic              Trig,
    output logic              Armed,
    output logic              Busy,
    output logic [15:0]       TrigCount
);

    // Parameter sanity, evaluated at elaboration only.
    if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_bad_filt_len
        $error("trig_edge_qual: FILT_LEN must be in 2..16");
    end
    if (HOLD_W < 1) begin : g_bad_hold_w
        $error("trig_edge_qual: HOLD_W must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              filt;
    logic              filt_prev;
    logic              edge_det;
    logic              fire;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       trig_cnt;

    // ------------------------------------------------------------------
    // Level path
    // ------------------------------------------------------------------
`ifdef TRIG_GLITCH_FILTER_EN
    logic [FILT_LEN-1:0] filt_sr;

    // The filtered level only moves when the whole window agrees, so any
    // pulse shorter than FILT_LEN samples leaves filt untouched.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            filt_sr <= '0;
            filt    <= 1'b0;
        end else begin
            filt_sr <= {filt_sr[FILT_LEN-2:0], Sin};
            if (&filt_sr) begin
                filt <= 1'b1;
            end else if (~|filt_sr) begin
                filt <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge Clock) begin
        if (Reset) begin
            filt <= 1'b0;
        end else begin
            filt <= Sin;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            filt_prev <= 1'b0;
        end else begin
            filt_prev <= filt;
        end
    end

    // Rising edges only; falling edges are never trigger candidates.
    assign edge_det = filt & ~filt_prev;

    // A trigger is issued only from ARMED, and Disarm suppresses it so the
    // FSM and the pulse never disagree about the outcome of that cycle.
    assign fire = (state == ST_ARMED) && edge_det && !Disarm;

    // ------------------------------------------------------------------
    // Arm FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arm FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (Disarm) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Arm) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (edge_det) begin
                        if (Holdoff != '0) begin
                            state_nxt = ST_HOLDOFF;
                        end else if (Single) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // Leave on the last dead cycle; the <= guard also
                    // recovers from a counter that is somehow already zero.
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state_nxt = Single ? ST_IDLE : ST_ARMED;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arm FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        Armed = 1'b0;
        Busy  = 1'b0;
        case (state)
            ST_ARMED:   Armed = 1'b1;
            ST_HOLDOFF: Busy  = 1'b1;
            default: begin
                Armed = 1'b0;
                Busy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holdoff counter: loaded with Holdoff on the trigger edge, so the
    // FSM spends exactly Holdoff cycles in HOLDOFF (values N..1).
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_cnt <= '0;
        end else if (Disarm) begin
            hold_cnt <= '0;
        end else if (fire) begin
            hold_cnt <= Holdoff;
        end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Trigger pulse and count. Trig is registered, so a pulse already
    // issued finishes its cycle even if Disarm arrives right after.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Trig     <= 1'b0;
            trig_cnt <= '0;
        end else begin
            Trig <= fire;
            if (fire) begin
                trig_cnt <= trig_cnt + 16'd1;
            end
        end
    end

    assign TrigCount = trig_cnt;

endmodule

// File: tb/tb_trig_edge_qual.sv
// Purpose : directed self-checking bench for trig_edge_qual.
// Latency : expected Sin-to-Trig latency follows the filter build option.
// Backpr. : n/a.

module tb_trig_edge_qual;

    localparam int FILT_LEN = 4;
    localparam int HOLD_W   = 16;

`ifdef TRIG_GLITCH_FILTER_EN
    // Edges from first high Sin sample up to and including the Trig edge.
    localparam int TL  = FILT_LEN + 2;
    localparam int PER = 2 * FILT_LEN;
    localparam int PULSE_TRIGS = 0;
`else
    localparam int TL  = 2;
    localparam int PER = 6;
    localparam int PULSE_TRIGS = 1;
`endif
    localparam int SETTLE = 2 * FILT_LEN + 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Sin;
    logic              Arm;
    logic              Disarm;
    logic              Single;
    logic [HOLD_W-1:0] Holdoff;
    logic              Trig;
    logic              Armed;
    logic              Busy;
    logic [15:0]       TrigCount;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tr;
    int n_busy;
    logic [15:0] exp_cnt;

    trig_edge_qual #(.FILT_LEN(FILT_LEN), .HOLD_W(HOLD_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Sin       (Sin),
        .Arm       (Arm),
        .Disarm    (Disarm),
        .Single    (Single),
        .Holdoff   (Holdoff),
        .Trig      (Trig),
        .Armed     (Armed),
        .Busy      (Busy),
        .TrigCount (TrigCount)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_once();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Sin = 1'b0; Arm = 1'b0; Disarm = 1'b0;
        Single = 1'b0; Holdoff = '0;
        ticks(2);
        Reset = 1'b0;
        tick();
        check("rst_trig",  {31'd0, Trig},  32'd0);
        check("rst_armed", {31'd0, Armed}, 32'd0);
        check("rst_busy",  {31'd0, Busy},  32'd0);
        check("rst_count", {16'd0, TrigCount}, 32'd0);
        exp_cnt = 16'd0;

        // Basic latency: continuous, no holdoff.
        arm_once();
        check("arm_armed", {31'd0, Armed}, 32'd1);
        Sin = 1'b1;
        n_tr = 0;
        for (int i = 0; i < TL - 1; i++) begin
            tick();
            n_tr += int'(Trig);
        end
        check("lat_early_trig", n_tr, 32'd0);
        tick();
        exp_cnt++;
        check("lat_trig", {31'd0, Trig}, 32'd1);
        check("lat_count", {16'd0, TrigCount}, {16'd0, exp_cnt});
        tick();
        check("lat_trig_one_cycle", {31'd0, Trig}, 32'd0);
        check("lat_still_armed", {31'd0, Armed}, 32'd1);
        Sin = 1'b0;
        ticks(SETTLE);

        // 3-cycle pulse: rejected by the filter, one trigger without it.
        n_tr = 0;
        Sin = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); n_tr += int'(Trig); end
        Sin = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin tick(); n_tr += int'(Trig); end
        exp_cnt += 16'(PULSE_TRIGS);
        check("pulse_trigs", n_tr, PULSE_TRIGS);
        check("pulse_count", {16'd0, TrigCount}, {16'd0, exp_cnt});

        // Holdoff=10 with edges every PER cycles: edges 1,3,5 fire.
        Holdoff = 16'd10;
        n_busy = 0;
        for (int p = 0; p < 5; p++) begin
            n_tr = 0;
            for (int c = 0; c < PER; c++) begin
                Sin = (c < PER / 2);
                tick();
                n_tr += int'(Trig);
                n_busy += int'(Busy);
            end
            check($sformatf("hold_period%0d", p + 1), n_tr, (p % 2 == 0) ? 1 : 0);
        end
        Sin = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); n_busy += int'(Busy); end
        exp_cnt += 16'd3;
        check("hold_busy_cycles", n_busy, 32'd30);
        check("hold_count", {16'd0, TrigCount}, {16'd0, exp_cnt});
        check("hold_rearmed", {31'd0, Armed}, 32'd1);
        ticks(SETTLE);

        // Single-shot with Holdoff=3.
        Single = 1'b1;
        Holdoff = 16'd3;
        Sin = 1'b1;
        ticks(TL);
        exp_cnt++;
        check("single_trig", {31'd0, Trig}, 32'd1);
        check("single_busy0", {31'd0, Busy}, 32'd1);
        tick();
        check("single_busy1", {31'd0, Busy}, 32'd1);
        tick();
        check("single_busy2", {31'd0, Busy}, 32'd1);
        tick();
        check("single_busy_end", {31'd0, Busy}, 32'd0);
        check("single_idle", {31'd0, Armed}, 32'd0);
        Sin = 1'b0;
        ticks(SETTLE);
        n_tr = 0;
        Sin = 1'b1;
        for (int i = 0; i < TL + 4; i++) begin tick(); n_tr += int'(Trig); end
        check("single_second_ignored", n_tr, 32'd0);
        check("single_count", {16'd0, TrigCount}, {16'd0, exp_cnt});
        Sin = 1'b0;
        ticks(SETTLE);

        // Arm together with Disarm stays IDLE.
        Single = 1'b0;
        Arm = 1'b1; Disarm = 1'b1;
        tick();
        Arm = 1'b0; Disarm = 1'b0;
        check("arm_disarm_idle", {31'd0, Armed}, 32'd0);

        // Disarm during HOLDOFF.
        Holdoff = 16'd5;
        arm_once();
        Sin = 1'b1;
        ticks(TL);
        exp_cnt++;
        check("dis_trig", {31'd0, Trig}, 32'd1);
        tick();
        check("dis_busy_before", {31'd0, Busy}, 32'd1);
        Disarm = 1'b1;
        tick();
        Disarm = 1'b0;
        check("dis_busy_after", {31'd0, Busy}, 32'd0);
        check("dis_armed_after", {31'd0, Armed}, 32'd0);
        Sin = 1'b0;
        ticks(SETTLE);
        n_tr = 0;
        Sin = 1'b1;
        for (int i = 0; i < TL + 2; i++) begin tick(); n_tr += int'(Trig); end
        check("dis_no_trig_idle", n_tr, 32'd0);
        Sin = 1'b0;
        ticks(SETTLE);

        // Counter wrap.
        Holdoff = 16'd0;
        arm_once();
        force dut.trig_cnt = 16'hFFFF;
        #1;
        release dut.trig_cnt;
        #1;
        check("wrap_preload", {16'd0, TrigCount}, 32'h0000FFFF);
        Sin = 1'b1;
        ticks(TL);
        check("wrap_trig", {31'd0, Trig}, 32'd1);
        check("wrap_count", {16'd0, TrigCount}, 32'd0);
        Sin = 1'b0;
        ticks(SETTLE);

        // Reset during HOLDOFF.
        Holdoff = 16'd10;
        Sin = 1'b1;
        ticks(TL);
        check("rh_trig", {31'd0, Trig}, 32'd1);
        check("rh_count", {16'd0, TrigCount}, 32'd1);
        ticks(2);
        check("rh_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        tick();
        check("rh_trig0",  {31'd0, Trig},  32'd0);
        check("rh_armed0", {31'd0, Armed}, 32'd0);
        check("rh_busy0",  {31'd0, Busy},  32'd0);
        check("rh_count0", {16'd0, TrigCount}, 32'd0);
        Reset = 1'b0;
        Sin = 1'b0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
